// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART_Tx side signals of the transmit arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_d;
  logic [N_REQ-1:0]   gnt;
  logic [7:0]         tx_d;
  logic               tx_wr;
  logic               txe;

  modport master (
    output req, req_d, txe,
    input  gnt, tx_d, tx_wr
  );

  modport slave (
    input  req, req_d, txe,
    output gnt, tx_d, tx_wr
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART_Tx between N_REQ byte producers
// Every output is a register loaded from the next-state logic, so GNT/TX_WR coincide with SEND.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  uart_tx_arbiter_if.slave       if_bus,
  output logic                   o_busy,
  output logic                   o_ack_err
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [7:0]       r_tx_d;
  logic             r_tx_wr;
  logic             r_busy;
  logic             r_ack_err;

  state_t           w_state_nxt;
  logic [PW-1:0]    w_ptr_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [7:0]       w_tx_d_nxt;
  logic             w_tx_wr_nxt;
  logic             w_busy_nxt;
  logic             w_ack_err_nxt;

  logic             w_found;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_cand;

  // Scan starts just after the last winner, so the last granted requester is checked last.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = r_ptr;
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = PW'((int'(r_ptr) + i) % N_REQ);
      if (!w_found && if_bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = '0;
    w_tx_d_nxt    = r_tx_d;
    w_tx_wr_nxt   = 1'b0;
    w_ack_err_nxt = r_ack_err;
    case (r_state)
      S_IDLE: begin
        if (if_bus.txe && w_found) begin
          w_state_nxt = S_SEND;
          w_ptr_nxt   = w_win;
          w_gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
          w_tx_d_nxt  = if_bus.req_d[8*w_win +: 8];
          w_tx_wr_nxt = 1'b1;
        end
      end
      S_SEND: begin
        w_state_nxt = S_WAIT_LOW;
        w_cnt_nxt   = '0;
      end
      S_WAIT_LOW: begin
        // TXE gets ACK_TIMEOUT samples in this state before the byte is given up on.
        if (!if_bus.txe) begin
          w_state_nxt = S_WAIT_HIGH;
        end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
          w_state_nxt   = S_IDLE;
          w_ack_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (if_bus.txe) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= PW'(N_REQ - 1);
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_tx_d    <= '0;
      r_tx_wr   <= 1'b0;
      r_busy    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_tx_d    <= w_tx_d_nxt;
      r_tx_wr   <= w_tx_wr_nxt;
      r_busy    <= w_busy_nxt;
      r_ack_err <= w_ack_err_nxt;
    end
  end

  assign if_bus.gnt   = r_gnt;
  assign if_bus.tx_d  = r_tx_d;
  assign if_bus.tx_wr = r_tx_wr;
  assign o_busy       = r_busy;
  assign o_ack_err    = r_ack_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic ack_err;

  logic model_en = 1'b0;
  logic txe_manual = 1'b1;
  logic txe_model = 1'b1;
  int   frame_cnt = 0;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] got_d;
  logic [3:0] got_g;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .ACK_TIMEOUT(16)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .if_bus    (bus),
    .o_busy    (busy),
    .o_ack_err (ack_err)
  );

  always #5 clk = ~clk;

  assign bus.txe = model_en ? txe_model : txe_manual;

  // UART_Tx stand-in: TXE falls the cycle after WR and rises 5 cycles later.
  always @(posedge clk) begin
    if (bus.tx_wr) begin
      txe_model <= 1'b0;
      frame_cnt <= 5;
    end else if (frame_cnt != 0) begin
      frame_cnt <= frame_cnt - 1;
      if (frame_cnt == 1) txe_model <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(output logic [7:0] d, output logic [3:0] g);
    int n;
    n = 0;
    tick();
    while (!bus.tx_wr && n < 100) begin
      tick();
      n++;
    end
    check("wr_timeout", 32'(bus.tx_wr), 1);
    d = bus.tx_d;
    g = bus.gnt;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req   = '0;
    bus.req_d = '0;
    tick();
    tick();
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_tx_d", 32'(bus.tx_d), 0);
    check("rst_tx_wr", 32'(bus.tx_wr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack_err", 32'(ack_err), 0);
    rst_n = 1'b1;
    model_en = 1'b1;

    // single request, one-cycle latency
    bus.req_d[7:0] = 8'h41;
    bus.req = 4'b0001;
    tick();
    check("t1_tx_wr", 32'(bus.tx_wr), 1);
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    check("t1_tx_d", 32'(bus.tx_d), 32'h41);
    check("t1_busy", 32'(busy), 1);
    bus.req = 4'b0000;
    tick();
    check("t1_wr_pulse", 32'(bus.tx_wr), 0);
    check("t1_gnt_pulse", 32'(bus.gnt), 0);
    wait_idle();
    check("t1_ack_err", 32'(ack_err), 0);
    check("t1_hold_d", 32'(bus.tx_d), 32'h41);

    // round robin with all four requesting
    do_reset();
    bus.req_d = 32'h13121110;
    bus.req = 4'b1111;
    wait_wr(got_d, got_g); check("rr0_d", 32'(got_d), 32'h10); check("rr0_g", 32'(got_g), 32'h1);
    wait_wr(got_d, got_g); check("rr1_d", 32'(got_d), 32'h11); check("rr1_g", 32'(got_g), 32'h2);
    wait_wr(got_d, got_g); check("rr2_d", 32'(got_d), 32'h12); check("rr2_g", 32'(got_g), 32'h4);
    wait_wr(got_d, got_g); check("rr3_d", 32'(got_d), 32'h13); check("rr3_g", 32'(got_g), 32'h8);
    wait_wr(got_d, got_g); check("rr4_d", 32'(got_d), 32'h10); check("rr4_g", 32'(got_g), 32'h1);

    // after req2 wins, 0101 must go to req0 then req2
    wait_wr(got_d, got_g); check("p1_d", 32'(got_d), 32'h11);
    wait_wr(got_d, got_g); check("p2_d", 32'(got_d), 32'h12);
    bus.req = 4'b0101;
    wait_wr(got_d, got_g); check("p3_d", 32'(got_d), 32'h10); check("p3_g", 32'(got_g), 32'h1);
    wait_wr(got_d, got_g); check("p4_d", 32'(got_d), 32'h12); check("p4_g", 32'(got_g), 32'h4);
    bus.req = 4'b0000;
    tick();
    wait_idle();

    // TXE stuck high after TX_WR
    model_en = 1'b0;
    txe_manual = 1'b1;
    bus.req_d = 32'h00000055;
    bus.req = 4'b0001;
    tick();
    check("to_tx_wr", 32'(bus.tx_wr), 1);
    bus.req = 4'b0000;
    for (int i = 0; i < 16; i++) tick();
    check("to_not_yet", 32'(ack_err), 0);
    check("to_busy_still", 32'(busy), 1);
    tick();
    check("to_ack_err", 32'(ack_err), 1);
    check("to_idle", 32'(busy), 0);
    bus.req_d = 32'h00002200;
    bus.req = 4'b0010;
    tick();
    check("to_regrant_wr", 32'(bus.tx_wr), 1);
    check("to_regrant_g", 32'(bus.gnt), 32'h2);
    check("to_regrant_d", 32'(bus.tx_d), 32'h22);
    bus.req = 4'b0000;
    tick();
    txe_manual = 1'b0;
    tick(); tick(); tick();
    txe_manual = 1'b1;
    tick();
    wait_idle();
    check("to_sticky", 32'(ack_err), 1);

    // asynchronous reset while waiting for TXE to return
    model_en = 1'b1;
    bus.req_d = 32'h00770000;
    bus.req = 4'b0100;
    wait_wr(got_d, got_g);
    check("ar_d", 32'(got_d), 32'h77);
    bus.req = 4'b0000;
    tick(); tick(); tick();
    check("ar_in_frame", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_gnt", 32'(bus.gnt), 0);
    check("ar_tx_d", 32'(bus.tx_d), 0);
    check("ar_tx_wr", 32'(bus.tx_wr), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_ack_err", 32'(ack_err), 0);
    tick();
    rst_n = 1'b1;
    bus.req_d = 32'h13121110;
    bus.req = 4'b1111;
    wait_wr(got_d, got_g);
    check("ar_first_d", 32'(got_d), 32'h10);
    check("ar_first_g", 32'(got_g), 32'h1);
    bus.req = 4'b0000;
    tick();
    wait_idle();

    // TXE low in IDLE holds off arbitration
    model_en = 1'b0;
    txe_manual = 1'b0;
    bus.req_d = 32'h0000A500;
    bus.req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("tl_no_wr", 32'(bus.tx_wr), 0);
      check("tl_no_gnt", 32'(bus.gnt), 0);
    end
    txe_manual = 1'b1;
    tick();
    check("tl_wr", 32'(bus.tx_wr), 1);
    check("tl_gnt", 32'(bus.gnt), 32'h2);
    check("tl_d", 32'(bus.tx_d), 32'hA5);
    bus.req = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
